// File: rtl/nios2_mul_seq.sv
// rtl/nios2_mul_seq.sv - multi-cycle multiply sequencer feeding the Nios II 32x32 low-word multiply cell
module nios2_mul_seq #(
    parameter int CELL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    input  logic [31:0] cell_result
);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, FIX, DONE} state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXSU = 2'b10;
    localparam logic [1:0] OP_MULXSS = 2'b11;

    state_t      state, state_nxt;
    logic [31:0] a_q, b_q;
    logic [1:0]  op_q;
    logic [1:0]  pass_q;
    logic [1:0]  drain_q;
    logic [63:0] acc_q;
    logic [31:0] result_q;

    logic [CELL_LATENCY-1:0] tag_v;
    logic [1:0]              tag_p [CELL_LATENCY];

    logic        issuing;
    logic        last_pass;
    logic        drain_last;
    logic        tag_emerge;
    logic [5:0]  shift_amt;
    logic [63:0] acc_sum;
    logic [31:0] hi_fix;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        cell_src1  = 32'd0;
        cell_src2  = 32'd0;
        issuing    = 1'b0;
        last_pass  = (op_q == OP_MUL) || (pass_q == 2'd3);
        drain_last = (drain_q == 2'(CELL_LATENCY - 1));
        case (state)
            IDLE: begin
                req_ready = !reset;
                if (req_valid && !reset) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                issuing = 1'b1;
                if (!reset) begin
                    // mul uses the full words; mulx passes use zero-extended 16-bit halves
                    if (op_q == OP_MUL) begin
                        cell_src1 = a_q;
                        cell_src2 = b_q;
                    end else begin
                        cell_src1 = {16'd0, pass_q[0] ? a_q[31:16] : a_q[15:0]};
                        cell_src2 = {16'd0, pass_q[1] ? b_q[31:16] : b_q[15:0]};
                    end
                end
                if (last_pass) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_last) begin
                    state_nxt = (op_q == OP_MUL) ? DONE : FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
                resp_valid = !reset;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Each tag carries its pass index so the returning word lands at the right shift
    always_comb begin
        tag_emerge = tag_v[CELL_LATENCY-1];
        case (tag_p[CELL_LATENCY-1])
            2'd0:    shift_amt = 6'd0;
            2'd3:    shift_amt = 6'd32;
            default: shift_amt = 6'd16;
        endcase
        acc_sum = acc_q + ({32'd0, cell_result} << shift_amt);
        hi_fix  = acc_q[63:32];
        if ((op_q == OP_MULXSU || op_q == OP_MULXSS) && a_q[31]) begin
            hi_fix = hi_fix - b_q;
        end
        if (op_q == OP_MULXSS && b_q[31]) begin
            hi_fix = hi_fix - a_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            op_q     <= OP_MUL;
            pass_q   <= 2'd0;
            drain_q  <= 2'd0;
            acc_q    <= 64'd0;
            result_q <= 32'd0;
            tag_v    <= '0;
            for (int i = 0; i < CELL_LATENCY; i++) begin
                tag_p[i] <= 2'd0;
            end
        end else begin
            tag_v[0] <= issuing;
            tag_p[0] <= (op_q == OP_MUL) ? 2'd0 : pass_q;
            for (int i = CELL_LATENCY - 1; i > 0; i--) begin
                tag_v[i] <= tag_v[i-1];
                tag_p[i] <= tag_p[i-1];
            end
            if (state == IDLE && req_valid) begin
                a_q     <= req_src1;
                b_q     <= req_src2;
                op_q    <= req_op;
                pass_q  <= 2'd0;
                drain_q <= 2'd0;
                acc_q   <= 64'd0;
            end
            if (state == ISSUE) begin
                pass_q <= pass_q + 2'd1;
            end
            if (state == DRAIN) begin
                drain_q <= drain_q + 2'd1;
            end
            if (tag_emerge) begin
                acc_q <= acc_sum;
            end
            // The mul pass always emerges on the final drain cycle
            if (state == DRAIN && drain_last && op_q == OP_MUL) begin
                result_q <= acc_sum[31:0];
            end
            if (state == FIX) begin
                result_q <= hi_fix;
            end
        end
    end

    assign resp_result = result_q;

endmodule

// File: tb/tb_nios2_mul_seq.sv
// tb/tb_nios2_mul_seq.sv - scoreboard bench for nios2_mul_seq at cell latencies 1 and 3
module tb_nios2_mul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [1:0] done = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          hs;
        int          lat;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb, prod;
        xa   = ((op == 2'b10 || op == 2'b11) && a[31]) ? {32'hFFFFFFFF, a} : {32'h0, a};
        xb   = (op == 2'b11 && b[31]) ? {32'hFFFFFFFF, b} : {32'h0, b};
        prod = xa * xb;
        return (op == 2'b00) ? prod[31:0] : prod[63:32];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int L = (g == 0) ? 1 : 3;

        logic        reset;
        logic        req_valid, req_ready, resp_valid, resp_ready;
        logic [1:0]  req_op;
        logic [31:0] req_src1, req_src2, resp_result;
        logic [31:0] cell_src1, cell_src2, cell_result;
        logic [31:0] pipe [L];

        always @(posedge clk) begin
            pipe[0] <= cell_src1 * cell_src2;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign cell_result = pipe[L-1];

        nios2_mul_seq #(.CELL_LATENCY(L)) dut (
            .clk(clk), .reset(reset),
            .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
            .req_src1(req_src1), .req_src2(req_src2),
            .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
            .cell_src1(cell_src1), .cell_src2(cell_src2), .cell_result(cell_result)
        );

        exp_t        q[$];
        int          stall = 0;
        bit          rand_ready = 1'b0;
        int          last_resp_cyc = -10;
        logic [31:0] held = 32'd0;

        initial begin : monitor
            bit   prev_v;
            exp_t e;
            prev_v     = 1'b0;
            resp_ready = 1'b1;
            forever begin
                @(negedge clk);
                if (reset) begin
                    prev_v = 1'b0;
                    continue;
                end
                if (resp_valid && stall > 0) begin
                    resp_ready = 1'b0;
                    stall--;
                    check($sformatf("L%0d busy req_ready", L), {31'd0, req_ready}, 32'd0);
                end else begin
                    resp_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                if (resp_valid && !prev_v) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL L%0d unexpected response: got %h expected none", L, resp_result);
                    end else begin
                        check($sformatf("L%0d latency", L), 32'(cyc - q[0].hs), 32'(q[0].lat));
                    end
                    held = resp_result;
                end else if (resp_valid) begin
                    check($sformatf("L%0d result hold", L), resp_result, held);
                end
                if (resp_valid && resp_ready && q.size() > 0) begin
                    e = q.pop_front();
                    check($sformatf("L%0d result", L), resp_result, e.res);
                    last_resp_cyc = cyc;
                end
                prev_v = resp_valid;
            end
        end

        task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input bit push, input logic [31:0] exp, output int hs);
            int n;
            @(negedge clk);
            req_valid = 1'b1;
            req_op    = op;
            req_src1  = a;
            req_src2  = b;
            n = 0;
            while (!req_ready && n < 300) begin
                @(negedge clk);
                n++;
            end
            hs = cyc;
            if (!req_ready) begin
                checks++;
                errors++;
                $display("FAIL L%0d accept timeout: got req_ready=0 expected 1", L);
                req_valid = 1'b0;
                return;
            end
            if (push) q.push_back('{exp, cyc, (op == 2'b00) ? 2 + L : 6 + L});
            @(posedge clk);
            #1 req_valid = 1'b0;
        endtask

        task automatic wait_drain();
            int n;
            n = 0;
            while (q.size() != 0 && n < 500) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL L%0d drain timeout: got %0d pending expected 0", L, q.size());
                q.delete();
            end
        endtask

        initial begin : stim
            int hs, hs2;
            logic [1:0]  op;
            logic [31:0] a, b;
            reset     = 1'b1;
            req_valid = 1'b0;
            req_op    = 2'b00;
            req_src1  = 32'd0;
            req_src2  = 32'd0;
            repeat (3) @(negedge clk);
            check($sformatf("L%0d rst req_ready", L), {31'd0, req_ready}, 32'd0);
            check($sformatf("L%0d rst resp_valid", L), {31'd0, resp_valid}, 32'd0);
            check($sformatf("L%0d rst resp_result", L), resp_result, 32'd0);
            check($sformatf("L%0d rst cell_src1", L), cell_src1, 32'd0);
            check($sformatf("L%0d rst cell_src2", L), cell_src2, 32'd0);
            reset = 1'b0;
            @(negedge clk);
            check($sformatf("L%0d post-rst req_ready", L), {31'd0, req_ready}, 32'd1);

            issue(2'b00, 32'h00010003, 32'h00020005, 1, 32'h000B000F, hs);
            issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, hs);
            issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000001, hs);
            issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000000, hs);
            issue(2'b11, 32'h80000000, 32'h80000000, 1, 32'h40000000, hs);
            issue(2'b10, 32'hFFFFFFFF, 32'h00000002, 1, 32'hFFFFFFFF, hs);
            wait_drain();

            stall = 5;
            issue(2'b00, 32'd7, 32'd6, 1, 32'd42, hs);
            issue(2'b01, 32'h00010000, 32'h00010000, 1, 32'h00000001, hs2);
            check($sformatf("L%0d back-to-back accept", L), 32'(hs2 - last_resp_cyc), 32'd1);
            wait_drain();

            // Reset lands while the third mulxss pass is on the cell inputs
            issue(2'b11, 32'h12345678, 32'h9ABCDEF0, 0, 32'd0, hs);
            repeat (2) @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
            #1;
            check($sformatf("L%0d midrst req_ready", L), {31'd0, req_ready}, 32'd0);
            check($sformatf("L%0d midrst cell_src1", L), cell_src1, 32'd0);
            check($sformatf("L%0d midrst cell_src2", L), cell_src2, 32'd0);
            check($sformatf("L%0d midrst resp_valid", L), {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
            check($sformatf("L%0d midrst resp_result", L), resp_result, 32'd0);
            reset = 1'b0;
            @(negedge clk);
            check($sformatf("L%0d midrst release req_ready", L), {31'd0, req_ready}, 32'd1);
            repeat (15) @(negedge clk);
            issue(2'b00, 32'd3, 32'd5, 1, 32'd15, hs);
            wait_drain();

            rand_ready = 1'b1;
            for (int i = 0; i < 1000; i++) begin
                op = 2'($urandom_range(0, 3));
                a  = $urandom;
                b  = $urandom;
                if ($urandom_range(0, 7) == 0) a = {a[31], 31'd0};
                if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
                issue(op, a, b, 1, ref_model(op, a, b), hs);
            end
            wait_drain();
            done[g] = 1'b1;
        end
    end

    initial begin : finisher
        int n;
        n = 0;
        while (done != 2'b11 && n < 90000) begin
            @(posedge clk);
            n++;
        end
        if (done != 2'b11) begin
            checks++;
            errors++;
            $display("FAIL global timeout: got done=%b expected 11", done);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
